ultrasonic_ranger: RTL and testbench
====================================

// Module: ultrasonic_ranger
// PURPOSE
//   Drives an HC-SR04-style ultrasonic sensor (trigger pulse out, echo pulse in).
//   Measures the echo high time in clk cycles and publishes it as a 22-bit distance
//   on an Avalon-MM slave register (addr 0). Sits directly upstream of the obstacle
//   avoider, which reads DISTANCE[21:0] every cycle to select motor speed / run.
// PARAMETERS
//   TRIG_CYCLES     500        trigger high time (10 us @ 50 MHz)
//   TIMEOUT_CYCLES  2_000_000  max wait for echo rise and max echo width (40 ms)
//   PERIOD_CYCLES   3_000_000  trigger-start to next trigger-start (60 ms); >= TRIG+2*TIMEOUT not required
//   DIST_W          22         distance field width; saturates at 2**DIST_W-1
// PORTS
//   clk          in   1   system clock
//   reset_n      in   1   asynchronous active-low reset
//   s_cs         in   1   Avalon chip select
//   s_read       in   1   read strobe (qualified by s_cs)
//   s_write      in   1   write strobe (qualified by s_cs)
//   s_address    in   3   register word address
//   s_writedata  in   32  write data
//   s_readdata   out  32  registered read data
//   trig         out  1   sensor trigger
//   echo         in   1   sensor echo (asynchronous; 2-flop synchronised inside)
//   meas_done    out  1   1-cycle pulse when DISTANCE/flags update
// BEHAVIOUR
//   Registers: 0 DISTANCE (RO) [21:0] cycles, [30] TIMEOUT, [31] VALID; 1 CONTROL (RW)
//   [0] ENABLE (reset 1); 2 COUNT (RO) [31:0] completed measurements, wraps 2^32-1->0;
//   3..7 read 0, writes ignored. Writes to 0/2 ignored.
//   Read latency 1: s_readdata updates on the edge after s_cs&s_read, holds otherwise.
//   Read on the same edge as a DISTANCE update returns the pre-update value.
//   Reset: all regs 0 except ENABLE=1; s_readdata=0, trig=0, meas_done=0, state IDLE.
//   FSM (period counter runs from TRIG entry, free of echo):
//     IDLE     : ENABLE=1 -> TRIG, clear period counter.
//     TRIG     : trig=1 for exactly TRIG_CYCLES cycles -> WAIT_RISE.
//     WAIT_RISE: sync echo rising edge -> MEASURE (width counter=0);
//                TIMEOUT_CYCLES with no rise -> record timeout -> HOLDOFF.
//     MEASURE  : count each cycle echo high; falling edge -> record count -> HOLDOFF;
//                count reaches TIMEOUT_CYCLES -> record timeout -> HOLDOFF.
//     HOLDOFF  : wait until period counter = PERIOD_CYCLES-1 -> IDLE.
//   Record: DISTANCE <= min(count, 2**DIST_W-1), VALID=1, TIMEOUT=0, COUNT++,
//   meas_done=1 one cycle. Timeout record: DISTANCE=all-ones, TIMEOUT=1, VALID=1.
//   Echo already high in WAIT_RISE entry: not a rising edge; wait for low then rise.
//   ENABLE cleared mid-cycle: trig=0 next cycle, -> IDLE, no record, DISTANCE retained.
//   Write to CONTROL same cycle as measurement completion: both take effect.
//   Echo glitches: edges taken on synchronised signal only; 1-cycle pulses counted.
//   Width arithmetic: counters ceil(log2(max param+1)) bits, no wrap (saturate).
// STRUCTURE
//   ultrasonic_pkg: state enum (IDLE,TRIG,WAIT_RISE,MEASURE,HOLDOFF), register
//   address localparams, DISTANCE bit positions, default timing constants.
//   Sub-module sync_edge: 2-flop synchroniser + registered rise/fall pulses for echo.
// TESTING
//   1 Echo high 5000 cycles after trig -> DISTANCE=5000, VALID=1, TIMEOUT=0, meas_done once.
//   2 No echo -> after TRIG_CYCLES+TIMEOUT_CYCLES, DISTANCE=22'h3FFFFF, TIMEOUT=1.
//   3 Echo stuck high -> MEASURE never entered, timeout record; trig period = PERIOD_CYCLES.
//   4 Write CONTROL=0 during MEASURE -> trig low, no meas_done, COUNT/DISTANCE unchanged.
//   5 Read addr 0 on completion edge -> old value, next read new; addr 5 reads 0.
//   6 Assert reset_n low mid-TRIG -> trig=0 immediately (async), all regs at reset values.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the ultrasonic ranger: FSM states, register map,
// DISTANCE word layout and default sensor timing at 50 MHz.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } state_e;

  localparam logic [2:0] ADDR_DISTANCE = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_COUNT    = 3'd2;

  localparam int DIST_BIT_TIMEOUT = 30;
  localparam int DIST_BIT_VALID   = 31;
  localparam int CTRL_BIT_ENABLE  = 0;

  localparam int unsigned DEF_TRIG_CYCLES    = 500;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 2_000_000;
  localparam int unsigned DEF_PERIOD_CYCLES  = 3_000_000;
  localparam int unsigned DEF_DIST_W         = 22;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_sync_edge.sv
// Two-flop synchroniser for an asynchronous input with registered rise/fall pulses
// that are high in the first cycle the synchronised level has changed.
module sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, rise_q, fall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      rise_q <= s1_q & ~s2_q;
      fall_q <= ~s1_q & s2_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger pulse, echo width measurement in clk cycles,
// results published through a small Avalon-MM register block.
module ultrasonic_ranger
  import ultrasonic_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int unsigned DIST_W         = DEF_DIST_W
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_cs,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [2:0]  s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        trig,
  input  logic        echo,
  output logic        meas_done,
  output logic [2:0]  dbg_state_o
);

  localparam int unsigned CNT_W = $clog2(max3(TRIG_CYCLES, TIMEOUT_CYCLES, PERIOD_CYCLES) + 1);
  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEAS_MAX    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [31:0]      DIST_MAX    = 32'((64'd1 << DIST_W) - 64'd1);

  // Bus: s_read/s_write count only when s_cs is high; no waitrequest, and s_readdata
  // is loaded on the edge that samples s_cs&s_read (latency 1) and held otherwise.

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   tmr_q, tmr_d, per_q, per_d;
  logic [DIST_W-1:0]  dist_q, dist_d;
  logic               timeout_q, timeout_d, valid_q, valid_d;
  logic [31:0]        count_q, count_d, rdata_q, rdata_d, rd_word;
  logic               enable_q, enable_d, done_q;
  logic               rec, rec_to;
  logic [CNT_W-1:0]   rec_val;
  logic               echo_rise, echo_fall;
  logic               unused_wdata;

  assign unused_wdata = ^s_writedata[31:1];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  sync_edge u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (echo),
    .rise_o  (echo_rise),
    .fall_o  (echo_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      per_q     <= '0;
      dist_q    <= '0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
      count_q   <= '0;
      enable_q  <= 1'b1;
      rdata_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      per_q     <= per_d;
      dist_q    <= dist_d;
      timeout_q <= timeout_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      enable_q  <= enable_d;
      rdata_q   <= rdata_d;
      done_q    <= rec;
    end
  end

  always_comb begin
    enable_d = enable_q;
    if (s_cs && s_write && (s_address == ADDR_CONTROL)) enable_d = s_writedata[CTRL_BIT_ENABLE];

    state_d = state_q;
    tmr_d   = tmr_q;
    per_d   = sat_inc(per_q);
    rec     = 1'b0;
    rec_to  = 1'b0;
    rec_val = '0;
    case (state_q)
      // The launching IDLE cycle counts toward the period so trigger starts are exactly PERIOD apart.
      IDLE: begin
        per_d   = CNT_W'(1);
        tmr_d   = '0;
        state_d = TRIG;
      end
      TRIG: begin
        if (tmr_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          tmr_d   = '0;
        end else begin
          tmr_d = sat_inc(tmr_q);
        end
      end
      // The rise cycle is itself an echo-high cycle, so the width count starts at one.
      WAIT_RISE: begin
        if (echo_rise) begin
          state_d = MEASURE;
          tmr_d   = CNT_W'(1);
        end else if (tmr_q >= WAIT_LAST) begin
          rec     = 1'b1;
          rec_to  = 1'b1;
          state_d = HOLDOFF;
        end else begin
          tmr_d = sat_inc(tmr_q);
        end
      end
      MEASURE: begin
        if (echo_fall) begin
          rec     = 1'b1;
          rec_val = tmr_q;
          state_d = HOLDOFF;
        end else if (tmr_q >= MEAS_MAX) begin
          rec     = 1'b1;
          rec_to  = 1'b1;
          state_d = HOLDOFF;
        end else begin
          tmr_d = sat_inc(tmr_q);
        end
      end
      HOLDOFF: begin
        if (per_q >= PERIOD_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Disable acts on the write edge itself; a record completing on that edge still lands.
    if (!enable_d) state_d = IDLE;
  end

  always_comb begin
    dist_d    = dist_q;
    timeout_d = timeout_q;
    valid_d   = valid_q;
    count_d   = count_q;
    if (rec) begin
      valid_d   = 1'b1;
      timeout_d = rec_to;
      count_d   = count_q + 32'd1;
      if (rec_to || (32'(rec_val) > DIST_MAX)) dist_d = '1;
      else                                      dist_d = DIST_W'(rec_val);
    end
  end

  always_comb begin
    rd_word = '0;
    case (s_address)
      ADDR_DISTANCE: begin
        rd_word[DIST_W-1:0]       = dist_q;
        rd_word[DIST_BIT_TIMEOUT] = timeout_q;
        rd_word[DIST_BIT_VALID]   = valid_q;
      end
      ADDR_CONTROL: rd_word[CTRL_BIT_ENABLE] = enable_q;
      ADDR_COUNT:   rd_word = count_q;
      default:      rd_word = '0;
    endcase
    rdata_d = (s_cs && s_read) ? rd_word : rdata_q;
  end

  assign s_readdata  = rdata_q;
  assign trig        = (state_q == TRIG);
  assign meas_done   = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger with shortened timing: echo width vectors, timeouts,
// period, disable mid-measurement, read/update collision and asynchronous reset.
module tb_ultrasonic_ranger;
  import ultrasonic_pkg::*;

  localparam int TRIG    = 20;
  localparam int TIMEOUT = 5500;
  localparam int PERIOD  = 6000;
  localparam logic [31:0] TO_WORD = 32'hC03F_FFFF;

  logic        clk, reset_n, s_cs, s_read, s_write, trig, echo, meas_done;
  logic [2:0]  s_address, dbg_state;
  logic [31:0] s_writedata, s_readdata;

  ultrasonic_ranger #(
    .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TIMEOUT), .PERIOD_CYCLES(PERIOD), .DIST_W(22)
  ) dut (
    .clk(clk), .reset_n(reset_n), .s_cs(s_cs), .s_read(s_read), .s_write(s_write),
    .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .trig(trig), .echo(echo), .meas_done(meas_done), .dbg_state_o(dbg_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: trigger rises, meas_done pulses, MEASURE visits
  int   rise_cnt = 0, rise_cyc = 0, done_cnt = 0, done_cyc = 0;
  logic trig_prev = 1'b0, measure_seen = 1'b0;
  always @(negedge clk) begin
    if (trig && !trig_prev) begin rise_cnt++; rise_cyc = cyc; end
    trig_prev = trig;
    if (meas_done) begin done_cnt++; done_cyc = cyc; end
    if (dbg_state == 3'(MEASURE)) measure_seen = 1'b1;
  end

  // scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] last_dist;
  int          exp_count = 0, n_checks = 0, n_fail = 0;

  typedef struct { int delay; int width; logic [31:0] exp; } vec_t;
  vec_t vecs[6];

  function automatic logic [31:0] mk_dist(input int w);
    return 32'h8000_0000 | 32'(w);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks; all drive at negedge+1
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    s_cs = 1'b1; s_read = 1'b1; s_address = a;
    tick();
    d = s_readdata;
    s_cs = 1'b0; s_read = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    s_cs = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
    tick();
    s_cs = 1'b0; s_write = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic sb_check(input string name);
    logic [31:0] d;
    bus_read(ADDR_DISTANCE, d);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got 0x%08h", name, d);
    end else begin
      last_dist = exp_q.pop_front();
      n_checks--;
      check(name, d, last_dist);
    end
  endtask

  task automatic push_exp(input logic [31:0] e);
    exp_q.push_back(e);
    exp_count++;
  endtask

  task automatic wait_rise(input int n);
    for (int i = 0; i < 8000 && rise_cnt <= n; i++) tick();
    check("trig_rise_seen", 32'(rise_cnt > n), 32'd1);
  endtask

  task automatic wait_trig_low();
    for (int i = 0; i < 100 && trig; i++) tick();
    check("trig_fall_seen", 32'(trig), 32'd0);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 8000 && done_cnt <= n; i++) tick();
    check("meas_done_seen", 32'(done_cnt > n), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, d0, r0, a, target;
    vecs[0] = '{40, 5000, mk_dist(5000)};
    vecs[1] = '{5, 1, mk_dist(1)};
    vecs[2] = '{0, 0, TO_WORD};
    vecs[3] = '{0, 5510, TO_WORD};
    vecs[4] = '{100, 321, mk_dist(321)};
    vecs[5] = '{7, 5499, mk_dist(5499)};

    // reset; echo held high so the first measurement sees it already high
    reset_n = 1'b0; s_cs = 1'b0; s_read = 1'b0; s_write = 1'b0;
    s_address = '0; s_writedata = '0; echo = 1'b1;
    repeat (3) tick();
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_done", 32'(meas_done), 32'd0);
    check("rst_rdata", s_readdata, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset_n = 1'b1;
    read_check("rst_dist", ADDR_DISTANCE, 32'd0);
    read_check("rst_ctrl", ADDR_CONTROL, 32'd1);
    read_check("rst_count", ADDR_COUNT, 32'd0);
    read_check("rst_addr5", 3'd5, 32'd0);
    bus_write(ADDR_COUNT, 32'h0000_FFFF);
    bus_write(ADDR_DISTANCE, 32'h1234_5678);
    read_check("count_ro", ADDR_COUNT, 32'd0);

    // echo stuck high: no MEASURE, timeout record, exact trigger period
    wait_rise(0);
    a = rise_cyc;
    push_exp(TO_WORD);
    wait_done(0);
    check("stuck_latency", 32'(done_cyc - a), 32'(TRIG + TIMEOUT));
    check("stuck_no_measure", 32'(measure_seen), 32'd0);
    sb_check("stuck_dist");
    echo = 1'b0;
    wait_rise(1);
    check("trig_period", 32'(rise_cyc - a), 32'(PERIOD));
    seen = 1;

    // table-driven echo widths
    for (int i = 0; i < 6; i++) begin
      wait_rise(seen);
      seen = rise_cnt;
      d0 = done_cnt;
      wait_trig_low();
      repeat (vecs[i].delay) tick();
      push_exp(vecs[i].exp);
      if (vecs[i].width > 0) begin
        echo = 1'b1;
        repeat (vecs[i].width) tick();
        echo = 1'b0;
      end
      wait_done(d0);
      repeat (2) tick();
      check($sformatf("vec%0d_done_once", i), 32'(done_cnt), 32'(d0 + 1));
      sb_check($sformatf("vec%0d_dist", i));
      read_check($sformatf("vec%0d_count", i), ADDR_COUNT, 32'(exp_count));
    end

    // disable during MEASURE
    wait_rise(seen);
    seen = rise_cnt;
    wait_trig_low();
    repeat (10) tick();
    echo = 1'b1;
    repeat (200) tick();
    check("dis_in_measure", 32'(dbg_state), 32'(MEASURE));
    d0 = done_cnt;
    bus_write(ADDR_CONTROL, 32'd0);
    check("dis_state", 32'(dbg_state), 32'(IDLE));
    check("dis_trig", 32'(trig), 32'd0);
    repeat (300) tick();
    echo = 1'b0;
    r0 = rise_cnt;
    repeat (7000) tick();
    check("dis_no_done", 32'(done_cnt), 32'(d0));
    check("dis_no_trig", 32'(rise_cnt), 32'(r0));
    read_check("dis_count", ADDR_COUNT, 32'(exp_count));
    read_check("dis_dist", ADDR_DISTANCE, last_dist);
    read_check("dis_ctrl", ADDR_CONTROL, 32'd0);

    // re-enable; read DISTANCE on the completion edge of a no-echo timeout
    r0 = rise_cnt;
    bus_write(ADDR_CONTROL, 32'd1);
    wait_rise(r0);
    seen = rise_cnt;
    a = rise_cyc;
    target = a + TRIG + TIMEOUT - 1;
    for (int i = 0; i < 8000 && cyc < target; i++) tick();
    check("coll_align", 32'(cyc), 32'(target));
    read_check("coll_old", ADDR_DISTANCE, last_dist);
    check("coll_done", 32'(meas_done), 32'd1);
    push_exp(TO_WORD);
    sb_check("coll_new");
    read_check("coll_count", ADDR_COUNT, 32'(exp_count));
    read_check("addr5_zero", 3'd5, 32'd0);

    // asynchronous reset in the middle of TRIG
    read_check("pre_rst_count", ADDR_COUNT, 32'(exp_count));
    wait_rise(seen);
    repeat (5) tick();
    check("mid_trig", 32'(trig), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_trig", 32'(trig), 32'd0);
    check("arst_rdata", s_readdata, 32'd0);
    check("arst_state", 32'(dbg_state), 32'(IDLE));
    tick();
    reset_n = 1'b1;
    read_check("arst_dist", ADDR_DISTANCE, 32'd0);
    read_check("arst_count", ADDR_COUNT, 32'd0);
    read_check("arst_ctrl", ADDR_CONTROL, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
